// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit core's fetch stage: state encoding,
// redirect classification and the word width.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALT   = 2'd2
  } fetch_state_t;

  // Which source won the next-PC priority mux this cycle.
  typedef enum logic [2:0] {
    RK_RESET = 3'd0,
    RK_MEM   = 3'd1,
    RK_EVAC  = 3'd2,
    RK_HOLD  = 3'd3,
    RK_PRED  = 3'd4,
    RK_SEQ   = 3'd5
  } redirect_kind_t;

  function automatic logic is_miss(input redirect_kind_t kind);
    return (kind == RK_MEM) || (kind == RK_EVAC);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Pure-combinational next-PC priority mux; also reports which source was chosen
// so the fetch FSM can tell misprediction recoveries from ordinary steering.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              reset,
  input  logic              adr_miss,
  input  logic              pred_miss,
  input  logic              hold,
  input  logic              pred_take,
  input  logic [WORD_W-1:0] alu_res,
  input  logic [WORD_W-1:0] evac_adr,
  input  logic [WORD_W-1:0] pred_adr,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_next,
  output redirect_kind_t    redirect_kind
);

  always_comb begin
    pc_next       = pc + 16'd1;
    redirect_kind = RK_SEQ;
    if (reset) begin
      pc_next       = RESET_PC;
      redirect_kind = RK_RESET;
    end else if (adr_miss) begin
      pc_next       = alu_res;
      redirect_kind = RK_MEM;
    end else if (pred_miss) begin
      pc_next       = evac_adr;
      redirect_kind = RK_EVAC;
    end else if (hold) begin
      pc_next       = pc;
      redirect_kind = RK_HOLD;
    end else if (pred_take) begin
      pc_next       = pred_adr;
      redirect_kind = RK_PRED;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-steering stage: owns the PC, the synchronous imem
// address, the ID valid bit, back-end flush, halt and the redirect counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jump_pred,
  input  logic [15:0]      jump_pred_adr,
  input  logic             jump_pred_miss,
  input  logic             jump_pred_adr_miss,
  input  logic [15:0]      pcinc_evac,
  input  logic [15:0]      ALUres_mem,
  output logic [15:0]      imem_adr,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      inst_id,
  output logic [15:0]      pcinc_id,
  output logic             valid_id,
  output logic             flush_back,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [15:0]      pc_q, pc_d;
  logic [15:0]      pcinc_id_q, pcinc_id_d;
  fetch_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic           hold;
  logic           pred_take;
  logic           miss;
  redirect_kind_t redirect_kind;

  assign hold      = stall || (state_q == HALT);
  assign pred_take = jump_pred && (state_q == RUN);

  pc_next_sel #(
    .RESET_PC(RESET_PC)
  ) u_pc_next_sel (
    .reset        (reset),
    .adr_miss     (jump_pred_adr_miss),
    .pred_miss    (jump_pred_miss),
    .hold         (hold),
    .pred_take    (pred_take),
    .alu_res      (ALUres_mem),
    .evac_adr     (pcinc_evac),
    .pred_adr     (jump_pred_adr),
    .pc           (pc_q),
    .pc_next      (pc_d),
    .redirect_kind(redirect_kind)
  );

  // Reset is classified as its own kind, so a miss seen during reset never flushes.
  assign miss = is_miss(redirect_kind);

  always_comb begin
    state_d = state_q;
    if (miss) begin
      // HALT is sticky until reset; a late miss still steers the PC but not the FSM.
      state_d = (state_q == HALT) ? HALT : BUBBLE;
    end else if (state_q == HALT || stall) begin
      state_d = state_q;
    end else if (state_q == RUN && halt_req) begin
      state_d = HALT;
    end else if (state_q == RUN && jump_pred) begin
      state_d = BUBBLE;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    pcinc_id_d = (stall && !miss) ? pcinc_id_q : pc_q + 16'd1;
    cnt_d      = cnt_q;
    if (miss && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pcinc_id_q <= RESET_PC + 16'd1;
      state_q    <= BUBBLE;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pcinc_id_q <= pcinc_id_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_adr     = pc_d;
  assign inst_id      = imem_rdata;
  assign pcinc_id     = pcinc_id_q;
  assign valid_id     = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign flush_back   = miss;
  assign redirect_cnt = cnt_q;

endmodule
